// File: rtl/hgw_sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hgw_sram_arb_pkg
// Brief   : Shared types and limits for the hgw_sram_arb SRAM sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package hgw_sram_arb_pkg;

    localparam int N_MAX = 8;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/hgw_rr_arb.sv
`default_nettype none
// ============================================================================
// Module  : hgw_rr_arb
// Brief   : Combinational round-robin picker: first request at or above ptr.
// Revision: 1.0 - initial release
// ============================================================================
module hgw_rr_arb #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [PW-1:0] o_idx,
    output logic          o_valid
);

    localparam logic [PW:0] c_N = (PW+1)'(N);

    logic [PW:0]   w_sum;
    logic [PW-1:0] w_pos;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_sum   = '0;
        w_pos   = '0;
        for (int off = N - 1; off >= 0; off--) begin
            w_sum = {1'b0, i_ptr} + (PW+1)'(off);
            if (w_sum >= c_N) begin
                w_sum = w_sum - c_N;
            end
            w_pos = w_sum[PW-1:0];
            if (i_req[w_pos]) begin
                o_gnt        = '0;
                o_gnt[w_pos] = 1'b1;
                o_idx        = w_pos;
                o_valid      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hgw_sram_ff.sv
`default_nettype none
// ============================================================================
// Module  : hgw_sram_ff
// Brief   : Single-port flop-based SRAM, 1-cycle read latency (addr or data reg).
// Revision: 1.0 - initial release
// ============================================================================
module hgw_sram_ff #(
    parameter  int D       = 128,
    parameter  int W       = 32,
    parameter  int RD_TYPE = 0,
    localparam int AW      = $clog2(D)
) (
    input  logic          clk,
    input  logic          i_ce,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [W-1:0]  i_wdata,
    output logic [W-1:0]  o_rdata
);

    localparam logic [AW:0] c_DEPTH = (AW+1)'(D);

    logic [W-1:0] r_mem [D];
    logic         w_in_range;

    assign w_in_range = ({1'b0, i_addr} < c_DEPTH);

    // Array is deliberately unreset; the owner clears it after reset.
    always_ff @(posedge clk) begin
        if (i_ce && i_we && w_in_range) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    generate
        if (RD_TYPE == 0) begin : g_rd_addr
            logic [AW-1:0] r_addr;
            always_ff @(posedge clk) begin
                if (i_ce && !i_we) begin
                    r_addr <= i_addr;
                end
            end
            assign o_rdata = r_mem[r_addr];
        end else begin : g_rd_data
            logic [W-1:0] r_rdata;
            always_ff @(posedge clk) begin
                if (i_ce && !i_we) begin
                    r_rdata <= r_mem[i_addr];
                end
            end
            assign o_rdata = r_rdata;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/hgw_sram_arb.sv
`default_nettype none
// ============================================================================
// Module  : hgw_sram_arb
// Brief   : N-port round-robin arbiter/sequencer that clears, then shares one SRAM.
// Revision: 1.0 - initial release
// ============================================================================
module hgw_sram_arb
    import hgw_sram_arb_pkg::*;
#(
    parameter  int N       = 4,
    parameter  int D       = 128,
    parameter  int W       = 32,
    parameter  int RD_TYPE = 0,
    localparam int AW      = $clog2(D)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    req_we,
    input  logic [N*AW-1:0] req_addr,
    input  logic [N*W-1:0]  req_wdata,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    rvalid,
    output logic [W-1:0]    rdata,
    output logic            init_done
);

    localparam int            PW          = $clog2(N);
    localparam logic [AW-1:0] c_LAST_ADDR = AW'(D - 1);
    localparam logic [PW-1:0] c_LAST_PORT = PW'(N - 1);

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_clr_addr;
    logic [PW-1:0] r_rr_ptr;
    logic [N-1:0]  r_rvalid;

    logic [N-1:0]  w_arb_gnt;
    logic [PW-1:0] w_idx;
    logic          w_arb_valid;

    logic          w_ce;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [W-1:0]  w_wdata;

    hgw_rr_arb #(.N(N)) u_arb (
        .i_req   (req),
        .i_ptr   (r_rr_ptr),
        .o_gnt   (w_arb_gnt),
        .o_idx   (w_idx),
        .o_valid (w_arb_valid)
    );

    always_comb begin
        w_state_next = r_state;
        gnt          = '0;
        w_ce         = 1'b0;
        w_we         = 1'b0;
        w_addr       = r_clr_addr;
        w_wdata      = '0;
        case (r_state)
            ST_INIT: begin
                w_ce = 1'b1;
                w_we = 1'b1;
                if (r_clr_addr == c_LAST_ADDR) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                gnt     = w_arb_gnt;
                w_ce    = w_arb_valid;
                w_we    = w_arb_valid & req_we[w_idx];
                w_addr  = req_addr[w_idx*AW +: AW];
                w_wdata = req_wdata[w_idx*W +: W];
            end
            default: w_state_next = ST_INIT;
        endcase
    end

    // Granted reads are remembered one-hot; that register is rvalid itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_INIT;
            r_clr_addr <= '0;
            r_rr_ptr   <= '0;
            r_rvalid   <= '0;
        end else begin
            r_state  <= w_state_next;
            r_rvalid <= gnt & ~req_we;
            if (r_state == ST_INIT) begin
                r_clr_addr <= (r_clr_addr == c_LAST_ADDR) ? '0 : r_clr_addr + 1'b1;
            end
            if (r_state == ST_RUN && w_arb_valid) begin
                r_rr_ptr <= (w_idx == c_LAST_PORT) ? '0 : w_idx + 1'b1;
            end
        end
    end

    hgw_sram_ff #(
        .D       (D),
        .W       (W),
        .RD_TYPE (RD_TYPE)
    ) u_sram (
        .clk     (clk),
        .i_ce    (w_ce),
        .i_we    (w_we),
        .i_addr  (w_addr),
        .i_wdata (w_wdata),
        .o_rdata (rdata)
    );

    assign rvalid    = r_rvalid;
    assign init_done = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_hgw_sram_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_hgw_sram_arb
// Brief   : Directed bench driving both RD_TYPE variants with identical stimulus.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hgw_sram_arb;

    localparam int N  = 4;
    localparam int D  = 128;
    localparam int W  = 32;
    localparam int AW = 7;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N-1:0]    req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*W-1:0]  req_wdata;

    logic [N-1:0] gnt0, gnt1, rvalid0, rvalid1;
    logic [W-1:0] rdata0, rdata1;
    logic         init0, init1;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    hgw_sram_arb #(.N(N), .D(D), .W(W), .RD_TYPE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .gnt(gnt0), .rvalid(rvalid0), .rdata(rdata0), .init_done(init0)
    );

    hgw_sram_arb #(.N(N), .D(D), .W(W), .RD_TYPE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .gnt(gnt1), .rvalid(rvalid1), .rdata(rdata1), .init_done(init1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag, input logic [3:0] eg, input logic [3:0] ev,
                           input logic [31:0] ed, input logic eid);
        chk({tag, ".gnt0"},    64'(gnt0),    64'(eg));
        chk({tag, ".gnt1"},    64'(gnt1),    64'(eg));
        chk({tag, ".rvalid0"}, 64'(rvalid0), 64'(ev));
        chk({tag, ".rvalid1"}, 64'(rvalid1), 64'(ev));
        chk({tag, ".init0"},   64'(init0),   64'(eid));
        chk({tag, ".init1"},   64'(init1),   64'(eid));
        if (ev != 4'b0) begin
            chk({tag, ".rdata0"}, 64'(rdata0), 64'(ed));
            chk({tag, ".rdata1"}, 64'(rdata1), 64'(ed));
        end
    endtask

    // Inputs are driven 1 time unit after a rising edge, checked mid-cycle.
    task automatic cycle(input string tag, input logic [3:0] eg, input logic [3:0] ev,
                         input logic [31:0] ed, input logic eid);
        #4;
        chk_all(tag, eg, ev, ed, eid);
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic we, input logic [AW-1:0] a,
                            input logic [W-1:0] d);
        req[p]               = 1'b1;
        req_we[p]            = we;
        req_addr[p*AW +: AW] = a;
        req_wdata[p*W +: W]  = d;
    endtask

    task automatic clear_reqs();
        req    = '0;
        req_we = '0;
    endtask

    initial begin
        logic [AW-1:0] rb_addr [11];
        rb_addr = '{7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6, 7'd7, 7'd10, 7'd11, 7'd12};

        rst_n     = 1'b0;
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 4'b0000, 4'b0000, 32'h0, 1'b0);

        // Clear sequence with a read held throughout.
        rst_n = 1'b1;
        set_port(0, 1'b0, 7'd0, 32'h0);
        for (int i = 0; i < D; i++) cycle("init", 4'b0000, 4'b0000, 32'h0, 1'b0);

        // Sweep all addresses: every word reads back zero.
        for (int i = 0; i <= D; i++) begin
            if (i < D) set_port(0, 1'b0, AW'(i), 32'h0);
            else       clear_reqs();
            cycle("sweep", (i < D) ? 4'b0001 : 4'b0000, (i > 0) ? 4'b0001 : 4'b0000,
                  32'h0, 1'b1);
        end

        // Write then read-after-write from another port (ptr=1).
        set_port(1, 1'b1, 7'd5, 32'hDEADBEEF);
        cycle("raw_wr", 4'b0010, 4'b0000, 32'h0, 1'b1);
        clear_reqs();
        set_port(2, 1'b0, 7'd5, 32'h0);
        cycle("raw_rd", 4'b0100, 4'b0000, 32'h0, 1'b1);
        clear_reqs();
        cycle("raw_rv", 4'b0000, 4'b0100, 32'hDEADBEEF, 1'b1);

        // Port 3 preloads addr 0..7 with i*3, then reads them back to back.
        for (int i = 0; i < 8; i++) begin
            set_port(3, 1'b1, AW'(i), 32'(i * 3));
            cycle("preload", 4'b1000, 4'b0000, 32'h0, 1'b1);
        end
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) set_port(3, 1'b0, AW'(i), 32'h0);
            else       clear_reqs();
            cycle("b2b", (i < 8) ? 4'b1000 : 4'b0000, (i > 0) ? 4'b1000 : 4'b0000,
                  32'((i - 1) * 3), 1'b1);
        end

        // All four ports hold reads of their own index from ptr=0.
        for (int p = 0; p < N; p++) set_port(p, 1'b0, AW'(p), 32'h0);
        cycle("rr0", 4'b0001, 4'b0000, 32'h0, 1'b1);
        cycle("rr1", 4'b0010, 4'b0001, 32'd0, 1'b1);
        cycle("rr2", 4'b0100, 4'b0010, 32'd3, 1'b1);
        cycle("rr3", 4'b1000, 4'b0100, 32'd6, 1'b1);
        cycle("rr4", 4'b0001, 4'b1000, 32'd9, 1'b1);
        clear_reqs();
        cycle("rr5", 4'b0000, 4'b0001, 32'd0, 1'b1);

        // ptr=1: port1 beats port0, then the search wraps to port0.
        set_port(0, 1'b1, 7'd10, 32'hA0);
        set_port(1, 1'b1, 7'd11, 32'hB1);
        cycle("ptr1", 4'b0010, 4'b0000, 32'h0, 1'b1);
        set_port(1, 1'b1, 7'd12, 32'hC2);
        cycle("wrap", 4'b0001, 4'b0000, 32'h0, 1'b1);
        req[0] = 1'b0;
        cycle("ptr1b", 4'b0010, 4'b0000, 32'h0, 1'b1);
        clear_reqs();
        set_port(2, 1'b0, 7'd10, 32'h0);
        cycle("rd10", 4'b0100, 4'b0000, 32'h0, 1'b1);
        set_port(2, 1'b0, 7'd11, 32'h0);
        cycle("rd11", 4'b0100, 4'b0100, 32'hA0, 1'b1);
        set_port(2, 1'b0, 7'd12, 32'h0);
        cycle("rd12", 4'b0100, 4'b0100, 32'hB1, 1'b1);
        clear_reqs();
        cycle("rd12v", 4'b0000, 4'b0100, 32'hC2, 1'b1);

        // Reset in the cycle of a read grant: its rvalid must never appear.
        set_port(2, 1'b0, 7'd5, 32'h0);
        #4;
        chk_all("pre_rst", 4'b0100, 4'b0000, 32'h0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_all("rst_run", 4'b0000, 4'b0000, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        clear_reqs();
        chk_all("rst_run2", 4'b0000, 4'b0000, 32'h0, 1'b0);

        // Reset again mid-clear at clr_addr=40; full clear must restart.
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) cycle("init40", 4'b0000, 4'b0000, 32'h0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_all("rst_init", 4'b0000, 4'b0000, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < D; i++) cycle("reinit", 4'b0000, 4'b0000, 32'h0, 1'b0);

        // Previously written words are back to zero.
        for (int i = 0; i <= 11; i++) begin
            if (i < 11) set_port(0, 1'b0, rb_addr[i], 32'h0);
            else        clear_reqs();
            cycle("cleared", (i < 11) ? 4'b0001 : 4'b0000, (i > 0) ? 4'b0001 : 4'b0000,
                  32'h0, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
